// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared opcodes, data-processing cmd values, NV condition and FSM states
package instr_encoder_pkg;
  localparam logic [1:0] OP_DP = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR = 2'b10;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] COND_NV = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/instr_legal_chk.sv
// instr_legal_chk: flags whether cond/op/funct fall inside the subset the multicycle core decodes
// ports: cond/op/funct in, legal out (combinational)
module instr_legal_chk
  import instr_encoder_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output logic       legal
);
  logic dp_ok;
  always_comb begin
    dp_ok = funct[4:1] == CMD_ADD || funct[4:1] == CMD_SUB || funct[4:1] == CMD_AND ||
            funct[4:1] == CMD_ORR || funct[4:1] == CMD_EOR;
    legal = cond != COND_NV && (op == OP_DP  ? dp_ok :
                                op == OP_MEM ? !funct[2] && !funct[1] :
                                op == OP_BR  ? funct[5] : 1'b0);
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs legal instruction field beats into ARM words and writes them to memory from a base address
// ports: clk/reset (sync, active-low); start/base_adr session control; in_* field stream;
//        mem_we/mem_adr/mem_wd/mem_ack memory write; busy/done/err/err_count/word_count status
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [3:0]       in_cond,
  input  logic [1:0]       in_op,
  input  logic [5:0]       in_funct,
  input  logic [3:0]       in_rn,
  input  logic [3:0]       in_rd,
  input  logic [11:0]      in_src2,
  output logic             mem_we,
  output logic [31:0]      mem_adr,
  output logic [31:0]      mem_wd,
  input  logic             mem_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);
  state_t state, state_n;
  logic legal, take, ok, last_q;
  instr_legal_chk u_chk (.cond(in_cond), .op(in_op), .funct(in_funct), .legal(legal));
  assign take = in_valid && state == S_LOAD;
  assign ok = legal && word_count != CNT_W'(MAX_WORDS);
  assign in_ready = state == S_LOAD;
  assign mem_we = state == S_WRITE;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_n = !take ? S_LOAD : ok ? S_WRITE : in_last ? S_DONE : S_LOAD;
      S_WRITE: state_n = !mem_ack ? S_WRITE : last_q ? S_DONE : S_LOAD;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      mem_adr <= '0;
      mem_wd <= '0;
      last_q <= 1'b0;
      err <= 1'b0;
      err_count <= '0;
      word_count <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        mem_adr <= {base_adr[31:2], 2'b00};
        err <= 1'b0;
        err_count <= '0;
        word_count <= '0;
      end
      if (take && ok) begin
        mem_wd <= {in_cond, in_op, in_funct, in_rn, in_rd, in_src2};
        last_q <= in_last;
      end
      if (take && !ok) begin
        err <= 1'b1;
        err_count <= err_count + CNT_W'(1);
      end
      if (state == S_WRITE && mem_ack) begin
        mem_adr <= mem_adr + 32'd4;
        word_count <= word_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder
module tb_instr_encoder;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, mem_ack = 1'b0;
  logic [31:0] base_adr = '0;
  logic [3:0] in_cond = '0, in_rn = '0, in_rd = '0;
  logic [1:0] in_op = '0;
  logic [5:0] in_funct = '0;
  logic [11:0] in_src2 = '0;
  logic in_ready, mem_we, busy, done, err;
  logic [31:0] mem_adr, mem_wd;
  logic [8:0] err_count, word_count;
  int n_cmp = 0, n_bad = 0;
  instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .base_adr(base_adr), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct),
    .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wd(mem_wd), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err),
    .err_count(err_count), .word_count(word_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic begin_session(input logic [31:0] b);
    base_adr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic beat(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                      input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] s, input logic l);
    in_cond = c; in_op = o; in_funct = f; in_rn = rn; in_rd = rd; in_src2 = s; in_last = l;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic ack_after(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk({tag, " we held"}, {31'd0, mem_we}, 32'd1);
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_adr", mem_adr, 32'd0);
    chk("rst mem_wd", mem_wd, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst counts", {7'd0, err_count, 7'd0, word_count}, 32'd0);
    reset = 1'b1;
    tick();
    // 1: single ADD word
    begin_session(32'h100);
    chk("t1 in_ready", {31'd0, in_ready}, 32'd1);
    beat(4'hE, 2'b00, 6'b001000, 4'h1, 4'h2, 12'h003, 1'b1);
    chk("t1 mem_we", {31'd0, mem_we}, 32'd1);
    chk("t1 in_ready low", {31'd0, in_ready}, 32'd0);
    chk("t1 mem_wd", mem_wd, 32'hE0812003);
    chk("t1 mem_adr", mem_adr, 32'h100);
    ack_after(0, "t1");
    chk("t1 done", {31'd0, done}, 32'd1);
    chk("t1 word_count", {23'd0, word_count}, 32'd1);
    tick();
    chk("t1 done pulse", {31'd0, done}, 32'd0);
    chk("t1 idle", {31'd0, busy}, 32'd0);
    // 2: three words, acks delayed 0/2/5
    begin_session(32'h0);
    beat(4'hE, 2'b00, 6'b000100, 4'h3, 4'h4, 12'h005, 1'b0);
    chk("t2 adr0", mem_adr, 32'h0);
    ack_after(0, "t2a");
    beat(4'hE, 2'b01, 6'b011001, 4'h5, 4'h6, 12'h010, 1'b0);
    chk("t2 adr1", mem_adr, 32'h4);
    chk("t2 ldr wd", mem_wd, 32'hE5956010);
    ack_after(2, "t2b");
    beat(4'h0, 2'b00, 6'b011000, 4'h7, 4'h8, 12'h0FF, 1'b1);
    chk("t2 adr2", mem_adr, 32'h8);
    chk("t2 orr wd", mem_wd, 32'h018780FF);
    ack_after(5, "t2c");
    chk("t2 done", {31'd0, done}, 32'd1);
    chk("t2 word_count", {23'd0, word_count}, 32'd3);
    tick();
    // 3: Op=11 reject then ADD last
    begin_session(32'h200);
    beat(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 12'h000, 1'b0);
    chk("t3 no write", {31'd0, mem_we}, 32'd0);
    chk("t3 still load", {31'd0, in_ready}, 32'd1);
    chk("t3 err", {31'd0, err}, 32'd1);
    chk("t3 err_count", {23'd0, err_count}, 32'd1);
    beat(4'hE, 2'b00, 6'b001000, 4'h1, 4'h2, 12'h003, 1'b1);
    chk("t3 adr", mem_adr, 32'h200);
    ack_after(1, "t3");
    chk("t3 word_count", {23'd0, word_count}, 32'd1);
    chk("t3 err hold", {22'd0, err, err_count}, 32'h201);
    tick();
    // 4: branch word, plus cond=NV / bad cmd / writeback rejects
    begin_session(32'h40);
    chk("t4 err cleared", {22'd0, err, err_count}, 32'd0);
    beat(4'hF, 2'b00, 6'b001000, 4'h1, 4'h2, 12'h003, 1'b0);
    beat(4'hE, 2'b00, 6'b010100, 4'h1, 4'h2, 12'h003, 1'b0);
    beat(4'hE, 2'b01, 6'b011011, 4'h1, 4'h2, 12'h003, 1'b0);
    beat(4'hE, 2'b01, 6'b011101, 4'h1, 4'h2, 12'h003, 1'b0);
    beat(4'hE, 2'b10, 6'b011111, 4'h1, 4'h2, 12'h003, 1'b0);
    chk("t4 rejects", {23'd0, err_count}, 32'd5);
    chk("t4 no write", {31'd0, mem_we}, 32'd0);
    beat(4'hE, 2'b10, 6'b101111, 4'hF, 4'hF, 12'hFFD, 1'b1);
    chk("t4 b wd", mem_wd, 32'hEAFFFFFD);
    ack_after(0, "t4");
    tick();
    // 5: address wraps past 2^32
    begin_session(32'hFFFFFFFC);
    beat(4'hE, 2'b00, 6'b000000, 4'h1, 4'h1, 12'h001, 1'b0);
    chk("t5 adr0", mem_adr, 32'hFFFFFFFC);
    ack_after(0, "t5a");
    beat(4'hE, 2'b00, 6'b000010, 4'h1, 4'h1, 12'h001, 1'b1);
    chk("t5 adr wrap", mem_adr, 32'h0);
    ack_after(0, "t5b");
    chk("t5 word_count", {23'd0, word_count}, 32'd2);
    tick();
    // 6: reset mid-write, start ignored while busy
    begin_session(32'h300);
    beat(4'hE, 2'b00, 6'b001000, 4'h1, 4'h2, 12'h003, 1'b0);
    chk("t6 in write", {31'd0, mem_we}, 32'd1);
    reset = 1'b0;
    tick();
    chk("t6 we after reset", {31'd0, mem_we}, 32'd0);
    chk("t6 busy after reset", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    begin_session(32'h300);
    base_adr = 32'h400;
    start = 1'b1;
    beat(4'hE, 2'b00, 6'b001000, 4'h1, 4'h2, 12'h003, 1'b1);
    start = 1'b0;
    chk("t6 start ignored", mem_adr, 32'h300);
    ack_after(0, "t6");
    tick();
    // empty session: only a rejected last beat
    begin_session(32'h0);
    beat(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 12'h000, 1'b1);
    chk("empty done", {31'd0, done}, 32'd1);
    chk("empty counts", {22'd0, err, err_count}, 32'h201);
    chk("empty words", {23'd0, word_count}, 32'd0);
    tick();
    // overflow: 256 words fill the session, the next legal beat is rejected
    begin_session(32'h0);
    for (int i = 0; i < 256; i++) begin
      beat(4'hE, 2'b00, 6'b001000, 4'h1, 4'h2, 12'h003, 1'b0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    chk("ovf word_count", {23'd0, word_count}, 32'd256);
    chk("ovf adr", mem_adr, 32'h400);
    beat(4'hE, 2'b00, 6'b001000, 4'h1, 4'h2, 12'h003, 1'b1);
    chk("ovf no write", {31'd0, mem_we}, 32'd0);
    chk("ovf done", {31'd0, done}, 32'd1);
    chk("ovf err", {22'd0, err, err_count}, 32'h201);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
